// File: rtl/uni_shift_reg_param.sv
// Parametrised universal shift register: shifts, rotates, arithmetic shift, load, clock enable.
// Define UNI_SHIFT_REG_CNT_SHIFT_EN to build the counted multi-bit shift engine (busy/done handshake).
module uni_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             cnt_dir,
    input  logic [CNT_W-1:0] cnt_amt,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHR   = 3'b001,
        M_SHL   = 3'b010,
        M_LOAD  = 3'b011,
        M_ROR   = 3'b100,
        M_ROL   = 3'b101,
        M_ASR   = 3'b110,
        M_COUNT = 3'b111
    } mode_t;

    // Result of every single-cycle mode; the counted-shift start code leaves q untouched.
    function automatic logic [WIDTH-1:0] single_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sil,
        input logic             sir,
        input logic [WIDTH-1:0] pin
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            M_SHR:   res = {sir, cur[WIDTH-1:1]};
            M_SHL:   res = {cur[WIDTH-2:0], sil};
            M_LOAD:  res = pin;
            M_ROR:   res = {cur[0], cur[WIDTH-1:1]};
            M_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: res = cur;
        endcase
        return res;
    endfunction

    assign serial_out_left  = q[WIDTH-1];
    assign serial_out_right = q[0];

`ifdef UNI_SHIFT_REG_CNT_SHIFT_EN

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    logic             dir, dir_next;
    logic             done_next;
    logic [WIDTH-1:0] q_next;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
            q         <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            dir       <= dir_next;
            done      <= done_next;
            q         <= q_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_next     = state;
        remaining_next = remaining;
        dir_next       = dir;
        done_next      = 1'b0;
        q_next         = q;
        if (en) begin
            case (state)
                S_IDLE: begin
                    if (mode == M_COUNT) begin
                        if (cnt_amt != '0) begin
                            state_next     = S_SHIFT;
                            remaining_next = cnt_amt;
                            dir_next       = cnt_dir;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        q_next = single_op(mode, q, serial_in_left, serial_in_right, parallel_in);
                    end
                end
                S_SHIFT: begin
                    q_next         = dir ? {q[WIDTH-2:0], serial_in_left}
                                         : {serial_in_right, q[WIDTH-1:1]};
                    remaining_next = remaining - CNT_W'(1);
                    // The edge consuming the last count already frees the engine for a new command.
                    if (remaining == CNT_W'(1)) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_SHIFT);
    end

`else

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= single_op(mode, q, serial_in_left, serial_in_right, parallel_in);
        end
    end

    assign busy = 1'b0;
    assign done = 1'b0;

    logic unused_cnt;
    assign unused_cnt = ^{cnt_dir, cnt_amt};

`endif

endmodule

// File: tb/tb_uni_shift_reg_param.sv
// Directed self-checking bench for uni_shift_reg_param (WIDTH=8, CNT_W=4); follows the
// counted-shift macro so both builds are checked against their own expected behaviour.
module tb_uni_shift_reg_param;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [2:0]       mode;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [WIDTH-1:0] parallel_in;
    logic             cnt_dir;
    logic [CNT_W-1:0] cnt_amt;
    logic [WIDTH-1:0] q;
    logic             serial_out_left;
    logic             serial_out_right;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    uni_shift_reg_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .en               (en),
        .mode             (mode),
        .serial_in_left   (serial_in_left),
        .serial_in_right  (serial_in_right),
        .parallel_in      (parallel_in),
        .cnt_dir          (cnt_dir),
        .cnt_amt          (cnt_amt),
        .q                (q),
        .serial_out_left  (serial_out_left),
        .serial_out_right (serial_out_right),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] value);
        mode        = 3'b011;
        parallel_in = value;
        tick();
        mode        = 3'b000;
    endtask

`ifdef UNI_SHIFT_REG_CNT_SHIFT_EN
    int busy_cycles;
    int done_seen;
`endif

    initial begin
        reset_n         = 1'b0;
        en              = 1'b1;
        mode            = 3'b000;
        serial_in_left  = 1'b0;
        serial_in_right = 1'b0;
        parallel_in     = '0;
        cnt_dir         = 1'b0;
        cnt_amt         = '0;
        #2;
        check("reset_q", 32'(q), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        tick();
        check("reset_held_q", 32'(q), 32'h00);
        reset_n = 1'b1;
        tick();

        load(8'hA5);
        check("load_a5", 32'(q), 32'hA5);
        check("sol_a5", 32'(serial_out_left), 32'h1);
        check("sor_a5", 32'(serial_out_right), 32'h1);

        mode = 3'b000; tick();
        check("hold_a5", 32'(q), 32'hA5);

        en = 1'b0; mode = 3'b001; serial_in_right = 1'b1; tick();
        check("en_low_freeze", 32'(q), 32'hA5);
        en = 1'b1;

        mode = 3'b001; serial_in_right = 1'b1; tick();
        check("shr_fill1", 32'(q), 32'hD2);

        load(8'hA5);
        mode = 3'b010; serial_in_left = 1'b0; tick();
        check("shl_fill0", 32'(q), 32'h4A);
        check("sol_4a", 32'(serial_out_left), 32'h0);
        check("sor_4a", 32'(serial_out_right), 32'h0);

        mode = 3'b010; serial_in_left = 1'b1; tick();
        check("shl_fill1", 32'(q), 32'h95);

        load(8'h80);
        mode = 3'b110; tick();
        check("asr_80", 32'(q), 32'hC0);

        load(8'h81);
        mode = 3'b100; tick();
        check("ror_81", 32'(q), 32'hC0);

        load(8'h81);
        mode = 3'b101; tick();
        check("rol_81", 32'(q), 32'h03);

`ifdef UNI_SHIFT_REG_CNT_SHIFT_EN
        // Counted right shift by 3 of 0xF0; a load requested while busy must be ignored.
        load(8'hF0);
        cnt_dir = 1'b0; cnt_amt = 4'd3; serial_in_right = 1'b0;
        mode = 3'b111; tick();
        check("cnt_start_busy", 32'(busy), 32'h1);
        check("cnt_start_q", 32'(q), 32'hF0);
        mode = 3'b011; parallel_in = 8'h55;
        busy_cycles = 0; done_seen = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            busy_cycles++;
            if (done) done_seen++;
            tick();
        end
        check("cnt_busy_cycles", 32'(busy_cycles), 32'd3);
        check("cnt_done_during_busy", 32'(done_seen), 32'd0);
        check("cnt_done_pulse", 32'(done), 32'h1);
        check("cnt_final_q", 32'(q), 32'h1E);
        // Command accepted on the done edge.
        parallel_in = 8'h3C; tick();
        check("cnt_accept_on_done", 32'(q), 32'h3C);
        check("cnt_done_cleared", 32'(done), 32'h0);
        mode = 3'b000;

        // Same counted shift with en dropped for two cycles mid-count.
        load(8'hF0);
        mode = 3'b111; tick();
        mode = 3'b000;
        busy_cycles = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            en = !(k == 1 || k == 2);
            busy_cycles++;
            tick();
        end
        en = 1'b1;
        check("stall_busy_cycles", 32'(busy_cycles), 32'd5);
        check("stall_done_pulse", 32'(done), 32'h1);
        check("stall_final_q", 32'(q), 32'h1E);

        // Counted shift left by 2 with fill 1.
        load(8'h81);
        cnt_dir = 1'b1; cnt_amt = 4'd2; serial_in_left = 1'b1;
        mode = 3'b111; tick();
        mode = 3'b000; cnt_dir = 1'b0;
        tick(); tick();
        check("cntl_final_q", 32'(q), 32'h07);
        check("cntl_done", 32'(done), 32'h1);

        // Zero count: no busy, one done pulse, q unchanged.
        load(8'h66);
        cnt_amt = 4'd0; mode = 3'b111; tick();
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_done", 32'(done), 32'h1);
        check("zero_q", 32'(q), 32'h66);
        mode = 3'b000; tick();
        check("zero_done_cleared", 32'(done), 32'h0);

        // Reset mid-count aborts without a done pulse.
        load(8'hF0);
        cnt_amt = 4'd5; mode = 3'b111; tick();
        mode = 3'b000;
        tick(); tick();
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        #2 reset_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        load(8'h5A);
        check("abort_next_cmd", 32'(q), 32'h5A);
`else
        // Without the counted-shift engine, mode 111 holds and busy/done stay low.
        load(8'hF0);
        cnt_dir = 1'b0; cnt_amt = 4'd3;
        mode = 3'b111; tick();
        check("nocnt_hold_q", 32'(q), 32'hF0);
        check("nocnt_busy", 32'(busy), 32'h0);
        check("nocnt_done", 32'(done), 32'h0);
        tick();
        check("nocnt_hold_q2", 32'(q), 32'hF0);
        mode = 3'b000;

        // Reset still clears the register asynchronously.
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_q", 32'(q), 32'h00);
        #2 reset_n = 1'b1;
        tick();
        load(8'h5A);
        check("post_reset_load", 32'(q), 32'h5A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
